// File: rtl/regwrite_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : regwrite_trace_buffer
// Purpose  : Watches the processor's regfile write port and stamps every
//            architecturally visible write (rd != 0) with a free-running
//            cycle count. The records are queued in a first-word-fall-through
//            FIFO and drained over a valid/ready stream to a logger or UART.
//            When the FIFO is full, a write is dropped and counted.
// Ports    : clock      - system clock, every state update on posedge
//            reset      - synchronous, active-low (0 = reset)
//            enable     - 1 = count cycles and capture writes
//            clear      - synchronous flush of FIFO, counters and flags
//            wb_we      - regfile write enable
//            wb_rd      - regfile write address
//            wb_data    - regfile write data
//            out_valid  - head record available
//            out_ready  - consumer accepts head record
//            out_cycle  - cycle stamp of head record (0 when empty)
//            out_rd     - register number of head record (0 when empty)
//            out_data   - write data of head record (0 when empty)
//            count      - entries currently held, 0..DEPTH
//            overflow   - sticky, at least one write was dropped
//            dropped    - dropped-write count, saturates at 16'hFFFF
// Revision : 1.0 - initial release
// ============================================================================
module regwrite_trace_buffer #(
  parameter int DEPTH   = 16,
  parameter int CYCLE_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     wb_we,
  input  logic [4:0]               wb_rd,
  input  logic [31:0]              wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CYCLE_W-1:0]       out_cycle,
  output logic [4:0]               out_rd,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              dropped
);

  localparam int                 c_AW        = $clog2(DEPTH);
  localparam logic [c_AW:0]      c_FULL      = (c_AW + 1)'(DEPTH);
  localparam logic [15:0]        c_DROP_MAX  = 16'hFFFF;

  // Record storage. The arrays carry no reset: nothing is ever read from a
  // slot that has not been written since the last reset/clear, because the
  // outputs are forced to 0 whenever the FIFO is empty.
  logic [CYCLE_W-1:0] r_mem_cycle [DEPTH];
  logic [4:0]         r_mem_rd    [DEPTH];
  logic [31:0]        r_mem_data  [DEPTH];

  logic [c_AW-1:0]    r_wr_ptr;
  logic [c_AW-1:0]    r_rd_ptr;
  logic [c_AW:0]      r_count;
  logic [CYCLE_W-1:0] r_cycle;
  logic               r_overflow;
  logic [15:0]        r_dropped;

  logic               w_push_req;
  logic               w_pop;
  logic               w_full;
  logic               w_push;
  logic               w_drop;

  // A capture request exists only for enabled writes to a real register.
  assign w_push_req = enable & wb_we & (wb_rd != 5'd0);
  assign w_full     = (r_count == c_FULL);
  // Pop is decided from the state before the edge, so a push into an empty
  // FIFO is never popped in the same cycle.
  assign w_pop      = (r_count != '0) & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  // Control state: pointers, occupancy, cycle counter and drop tracking.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_cycle    <= '0;
      r_overflow <= 1'b0;
      r_dropped  <= '0;
    end else if (clear) begin
      // clear wins over any push/pop arriving in the same cycle.
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_cycle    <= '0;
      r_overflow <= 1'b0;
      r_dropped  <= '0;
    end else begin
      if (enable) begin
        r_cycle <= r_cycle + CYCLE_W'(1);
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end

      // Occupancy moves only when exactly one side is active.
      if (w_push && !w_pop) begin
        r_count <= r_count + (c_AW + 1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (c_AW + 1)'(1);
      end

      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_dropped != c_DROP_MAX) begin
          r_dropped <= r_dropped + 16'd1;
        end
      end
    end
  end

  // Record write. The stamp is the counter value before this edge's
  // increment, i.e. the cycle in which the write was presented.
  always_ff @(posedge clock) begin
    if (reset && !clear && w_push) begin
      r_mem_cycle[r_wr_ptr] <= r_cycle;
      r_mem_rd[r_wr_ptr]    <= wb_rd;
      r_mem_data[r_wr_ptr]  <= wb_data;
    end
  end

  // First-word-fall-through head, zeroed when empty.
  assign out_valid = (r_count != '0);
  assign out_cycle = out_valid ? r_mem_cycle[r_rd_ptr] : '0;
  assign out_rd    = out_valid ? r_mem_rd[r_rd_ptr]    : '0;
  assign out_data  = out_valid ? r_mem_data[r_rd_ptr]  : '0;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign dropped   = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_regwrite_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_regwrite_trace_buffer
// Purpose  : Self-checking bench for regwrite_trace_buffer. Two instances
//            share one stimulus: a 16-bit-stamp instance and a 4-bit-stamp
//            instance used to exercise counter wrap. A queue of expected
//            records is filled as writes are driven and retired on pops;
//            every cycle the head of both DUTs is compared to the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regwrite_trace_buffer;

  typedef struct {
    logic [15:0] cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } rec_t;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        clear;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_ready;

  logic        out_valid;
  logic [15:0] out_cycle;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] dropped;

  logic        out_valid4;
  logic [3:0]  out_cycle4;
  logic [4:0]  out_rd4;
  logic [31:0] out_data4;
  logic [4:0]  count4;
  logic        overflow4;
  logic [15:0] dropped4;

  int          n_checks;
  int          n_errors;

  rec_t        exp_q[$];
  logic [15:0] exp_cycle;
  logic        exp_overflow;
  logic [15:0] exp_dropped;

  regwrite_trace_buffer #(.DEPTH(16), .CYCLE_W(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_cycle(out_cycle),
    .out_rd(out_rd), .out_data(out_data), .count(count),
    .overflow(overflow), .dropped(dropped)
  );

  regwrite_trace_buffer #(.DEPTH(16), .CYCLE_W(4)) dut4 (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_cycle(out_cycle4),
    .out_rd(out_rd4), .out_data(out_data4), .count(count4),
    .overflow(overflow4), .dropped(dropped4)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour, evaluated from the inputs presented at each edge.
  always @(posedge clock) begin
    if (!reset || clear) begin
      exp_q.delete();
      exp_cycle    = 16'd0;
      exp_overflow = 1'b0;
      exp_dropped  = 16'd0;
    end else begin
      automatic bit pop  = (exp_q.size() != 0) && out_ready;
      automatic bit req  = enable && wb_we && (wb_rd != 5'd0);
      automatic bit full = (exp_q.size() == 16);
      automatic rec_t r;
      r.cyc  = exp_cycle;
      r.rd   = wb_rd;
      r.data = wb_data;
      if (pop) void'(exp_q.pop_front());
      if (req && (!full || pop)) exp_q.push_back(r);
      else if (req) begin
        exp_overflow = 1'b1;
        if (exp_dropped != 16'hFFFF) exp_dropped = exp_dropped + 16'd1;
      end
      if (enable) exp_cycle = exp_cycle + 16'd1;
    end
  end

  // Head/flag comparison on the falling edge, away from the active edge.
  always @(negedge clock) begin
    automatic rec_t h;
    automatic bit has = (exp_q.size() != 0);
    h.cyc = 16'd0; h.rd = 5'd0; h.data = 32'd0;
    if (has) h = exp_q[0];
    check_value("valid",     {31'd0, out_valid},  {31'd0, has});
    check_value("count",     {27'd0, count},      exp_q.size());
    check_value("cycle",     {16'd0, out_cycle},  {16'd0, h.cyc});
    check_value("rd",        {27'd0, out_rd},     {27'd0, h.rd});
    check_value("data",      out_data,            h.data);
    check_value("overflow",  {31'd0, overflow},   {31'd0, exp_overflow});
    check_value("dropped",   {16'd0, dropped},    {16'd0, exp_dropped});
    check_value("valid4",    {31'd0, out_valid4}, {31'd0, has});
    check_value("count4",    {27'd0, count4},     exp_q.size());
    check_value("cycle4",    {28'd0, out_cycle4}, {28'd0, h.cyc[3:0]});
    check_value("rd4",       {27'd0, out_rd4},    {27'd0, h.rd});
    check_value("data4",     out_data4,           h.data);
    check_value("overflow4", {31'd0, overflow4},  {31'd0, exp_overflow});
    check_value("dropped4",  {16'd0, dropped4},   {16'd0, exp_dropped});
  end

  // Present one cycle of write-port stimulus; returns 1 time unit after the
  // edge that consumed it.
  task automatic drive(input logic we, input logic [4:0] rd,
                       input logic [31:0] data);
    wb_we   = we;
    wb_rd   = rd;
    wb_data = data;
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    enable    = 1'b0;
    clear     = 1'b0;
    wb_we     = 1'b0;
    wb_rd     = 5'd0;
    wb_data   = 32'd0;
    out_ready = 1'b0;
    drive(1'b1, 5'd3, 32'd9);   // write during reset must be ignored
    drive(1'b0, 5'd0, 32'd0);
    check_value("rst_count", {27'd0, count}, 32'd0);
    check_value("rst_valid", {31'd0, out_valid}, 32'd0);

    // T1: single record stamped at cycle 3, drained immediately
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) drive(1'b0, 5'd0, 32'd0);
    out_ready = 1'b1;
    drive(1'b1, 5'd5, 32'h0000_002A);
    check_value("t1_valid", {31'd0, out_valid}, 32'd1);
    check_value("t1_cycle", {16'd0, out_cycle}, 32'd3);
    check_value("t1_rd",    {27'd0, out_rd},    32'd5);
    check_value("t1_data",  out_data,           32'd42);
    drive(1'b0, 5'd0, 32'd0);
    check_value("t1_count", {27'd0, count}, 32'd0);

    // T2: r0 writes are never recorded
    drive(1'b1, 5'd0, 32'd7);
    check_value("t2_count", {27'd0, count}, 32'd0);
    check_value("t2_valid", {31'd0, out_valid}, 32'd0);

    // T3: fill and overflow by two
    out_ready = 1'b0;
    for (int i = 1; i <= 18; i++) drive(1'b1, 5'(i), 32'(i));
    check_value("t3_count",    {27'd0, count},    32'd16);
    check_value("t3_overflow", {31'd0, overflow}, 32'd1);
    check_value("t3_dropped",  {16'd0, dropped},  32'd2);
    check_value("t3_head_rd",  {27'd0, out_rd},   32'd1);

    // T4: push and pop at full, then drain
    out_ready = 1'b1;
    drive(1'b1, 5'd7, 32'd99);
    check_value("t4_count", {27'd0, count}, 32'd16);
    for (int i = 0; i < 15; i++) drive(1'b0, 5'd0, 32'd0);
    check_value("t4_last_rd",   {27'd0, out_rd}, 32'd7);
    check_value("t4_last_data", out_data,        32'd99);
    drive(1'b0, 5'd0, 32'd0);
    check_value("t4_empty", {27'd0, count}, 32'd0);

    // T5: stamp wrap on the 4-bit instance, then enable gap
    clear = 1'b1;
    drive(1'b0, 5'd0, 32'd0);
    clear = 1'b0;
    for (int i = 0; i < 20; i++) drive(1'b1, 5'(1 + (i % 31)), 32'(i));
    enable = 1'b0;
    repeat (3) drive(1'b1, 5'd4, 32'hDEAD);
    check_value("t5_gap_count", {27'd0, count}, 32'd0);
    enable = 1'b1;
    drive(1'b1, 5'd9, 32'd123);
    check_value("t5_resume16", {16'd0, out_cycle},  32'd20);
    check_value("t5_resume4",  {28'd0, out_cycle4}, 32'd4);
    drive(1'b0, 5'd0, 32'd0);

    // T6: reset and clear in the middle of a drain
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) drive(1'b1, 5'(i), 32'(i * 3));
    check_value("t6_count5", {27'd0, count}, 32'd5);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0);
    reset = 1'b1;
    check_value("t6_rst_count", {27'd0, count},     32'd0);
    check_value("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 1; i <= 5; i++) drive(1'b1, 5'(i), 32'(i * 5));
    clear = 1'b1;
    drive(1'b1, 5'd3, 32'd3);
    clear = 1'b0;
    check_value("t6_clr_count", {27'd0, count},     32'd0);
    check_value("t6_clr_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b0, 5'd0, 32'd0);
    check_value("t6_post_count", {27'd0, count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
